// File: rtl/top_pkg.sv
// Shared types and constant tables for the tone-generator synthesizer.
// The quarter-sine table is built at elaboration by a fixed-point Taylor series.
package top_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SAWTOOTH = 2'd3
    } wave_sel_e;

    // Phase increments for A3 (220 Hz) upward in semitones at 44.1 kHz.
    localparam logic [31:0] PHASE_INC [16] = '{
        32'd21426141, 32'd22700205, 32'd24050030, 32'd25480119,
        32'd26995246, 32'd28600467, 32'd30301139, 32'd32102938,
        32'd34011878, 32'd36034330, 32'd38177043, 32'd40447168,
        32'd42852281, 32'd45400411, 32'd48100060, 32'd50960238
    };

    typedef logic [255:0][15:0] sine_lut_t;

    localparam logic signed [127:0] PI_Q60 = 128'sd3622009729038561421;

    // Entry n is round(32767 * sin(pi/2 * (n + 0.5) / 256)), evaluated in Q60.
    function automatic sine_lut_t build_sine_lut();
        sine_lut_t lut;
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] acc;
        logic signed [127:0] scaled;
        lut = '0;
        for (int n = 0; n < 256; n++) begin
            x    = (PI_Q60 * 128'(2 * n + 1)) >>> 10;
            x2   = (x * x) >>> 60;
            term = x;
            acc  = x;
            for (int k = 1; k <= 10; k++) begin
                term = -(((term * x2) >>> 60) / 128'((2 * k) * (2 * k + 1)));
                acc  = acc + term;
            end
            scaled = (acc * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
            lut[8'(n)] = scaled[15:0];
        end
        return lut;
    endfunction

    localparam sine_lut_t SINE_LUT = build_sine_lut();

endpackage

// File: rtl/top_sine_lut.sv
// Quarter-wave sine lookup: folds the top 10 phase bits onto the 256-entry
// table and restores the sign for the lower half of the cycle.
module top_sine_lut
    import top_pkg::*;
(
    input  logic        [9:0]  phase,
    output logic signed [15:0] sine
);

    logic        [7:0]  idx;
    logic signed [15:0] mag;

    // Quadrants 1 and 3 read the table backwards (255 - i).
    assign idx  = phase[8] ? ~phase[7:0] : phase[7:0];
    assign mag  = signed'(SINE_LUT[idx]);
    assign sine = phase[9] ? -mag : mag;

endmodule

// File: rtl/top.sv
// Waveform synthesizer: phase accumulator, four waveshapes and output scaling.
// Define TOP_GAIN_EN for the percentage gain stage; otherwise output is raw >>> 1.
module top
    import top_pkg::*;
#(
    parameter int CLK_DIV = 256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic        [1:0]  wave_sel_i,
    input  logic        [3:0]  freq_sel_i,
    input  logic        [6:0]  gain_i,
    output logic signed [15:0] sample_o,
    output logic               sample_valid_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic        [CNT_W-1:0] cnt_q;
    logic        [31:0]      phase_q;
    logic                    tick;
    wave_sel_e               wave;
    logic        [15:0]      tri_t;
    logic signed [15:0]      sine_val;
    logic signed [15:0]      raw;
    logic signed [15:0]      scaled;

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign wave = wave_sel_e'(wave_sel_i);

    top_sine_lut u_sine (
        .phase (phase_q[31:22]),
        .sine  (sine_val)
    );

    // Triangle folds the second half of the cycle back down.
    assign tri_t = phase_q[31] ? ~phase_q[30:15] : phase_q[30:15];

    always_comb begin
        raw = {~phase_q[31], phase_q[30:16]};
        case (wave)
            WAVE_SINE:     raw = sine_val;
            WAVE_SQUARE:   raw = phase_q[31] ? -16'sd32767 : 16'sd32767;
            WAVE_TRIANGLE: raw = {~tri_t[15], tri_t[14:0]};
            default:       raw = {~phase_q[31], phase_q[30:16]};
        endcase
    end

`ifdef TOP_GAIN_EN
    logic        [6:0]  gain_sat;
    logic        [16:0] gain_scale;
    logic signed [39:0] product;

    // 655/65536 approximates 1/100, so gain_sat * 655 maps percent to Q16.
    assign gain_sat   = (gain_i > 7'd100) ? 7'd100 : gain_i;
    assign gain_scale = 17'(gain_sat) * 17'd655;
    assign product    = 40'(raw) * 40'($signed({1'b0, gain_scale}));
    assign scaled     = 16'(product >>> 16);
`else
    logic unused_gain;

    assign unused_gain = ^gain_i;
    assign scaled      = raw >>> 1;
`endif

    // Divider, accumulator and output registers all advance on the tick edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            phase_q        <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            if (tick) begin
                cnt_q          <= '0;
                phase_q        <= phase_q + PHASE_INC[freq_sel_i];
                sample_o       <= scaled;
                sample_valid_o <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: a real-arithmetic reference model predicts every
// output cycle; directed scenarios pin reset, first samples and phase behaviour.
// Honours TOP_GAIN_EN the same way the design does.
module tb_top;

    localparam int    CLK_DIV = 256;
    localparam real   PI      = 3.14159265358979323846;
    localparam longint TWO32  = 64'd4294967296;

`ifdef TOP_GAIN_EN
    localparam int EXP_SAW0  = -32750;
    localparam int EXP_SQ0   = 32749;
    localparam int EXP_SINE0 = 80;
`else
    localparam int EXP_SAW0  = -16384;
    localparam int EXP_SQ0   = 16383;
    localparam int EXP_SINE0 = 50;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic        [1:0]  wave_sel = 2'd3;
    logic        [3:0]  freq_sel = 4'd0;
    logic        [6:0]  gain = 7'd100;
    logic signed [15:0] sample;
    logic               sample_valid;

    int checks = 0;
    int errors = 0;

    longint inc_tab [16];
    int     lut_tab [256];

    longint m_phase = 0;
    longint m_cycle = 0;
    int     exp_sample = 0;
    bit     exp_valid = 1'b0;

    always #5 clk = ~clk;

    top #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wave_sel_i     (wave_sel),
        .freq_sel_i     (freq_sel),
        .gain_i         (gain),
        .sample_o       (sample),
        .sample_valid_o (sample_valid)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int w, input int f, input int g);
        wave_sel = 2'(w);
        freq_sel = 4'(f);
        gain     = 7'(g);
    endtask

    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int shapeRaw(input int w, input longint p);
        longint q, i, j, u, t;
        case (w)
            0: begin
                q = p / (64'd1 << 30);
                i = (p / (64'd1 << 22)) % 256;
                j = (q % 2 == 1) ? 255 - i : i;
                return (q >= 2) ? -lut_tab[j] : lut_tab[j];
            end
            1: return (p < (64'd1 << 31)) ? 32767 : -32767;
            2: begin
                u = p / 32768;
                t = (u < 65536) ? u : 131071 - u;
                return int'(t - 32768);
            end
            default: return int'(p / 65536 - 32768);
        endcase
    endfunction

    function automatic int applyGain(input int raw, input int g);
`ifdef TOP_GAIN_EN
        int gs;
        gs = (g > 100) ? 100 : g;
        return int'(floorDiv(longint'(raw) * gs * 655, 65536));
`else
        return int'(floorDiv(longint'(raw), 2));
`endif
    endfunction

    // Reference model: counts clock edges since reset release and emits a sample
    // from the accumulated phase on every CLK_DIV-th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    = 0;
            m_cycle    = 0;
            exp_sample = 0;
            exp_valid  = 1'b0;
        end else begin
            if (m_cycle % CLK_DIV == CLK_DIV - 1) begin
                exp_sample = applyGain(shapeRaw(int'(wave_sel), m_phase), int'(gain));
                m_phase    = (m_phase + inc_tab[freq_sel]) % TWO32;
                exp_valid  = 1'b1;
            end else begin
                exp_valid  = 1'b0;
            end
            m_cycle++;
        end
    end

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("valid", longint'(sample_valid), longint'(exp_valid));
            checkOutput("sample", longint'(sample), longint'(exp_sample));
        end
    end

    task automatic waitForValid(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge clk);
            cycles++;
            if (sample_valid) ok = 1'b1;
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        bit  ok;
        int  flip_idx;

        for (int k = 0; k < 16; k++)
            inc_tab[k] = longint'($floor(220.0 * (2.0 ** (real'(k) / 12.0)) * 4294967296.0 / 44100.0 + 0.5));
        for (int n = 0; n < 256; n++)
            lut_tab[n] = int'($floor(32767.0 * $sin(PI / 2.0 * (real'(n) + 0.5) / 256.0) + 0.5));

        checkOutput("model_inc0", inc_tab[0], 21426141);
        checkOutput("model_lut0", lut_tab[0], 101);
        checkOutput("model_lut255", lut_tab[255], 32767);
        checkOutput("model_saw0", applyGain(shapeRaw(3, 0), 100), EXP_SAW0);
        checkOutput("model_sq_sat", applyGain(shapeRaw(1, 0), 127), EXP_SQ0);

        applyStimulus(3, 0, 100);
        repeat (3) @(negedge clk);
        checkOutput("reset_sample", longint'(sample), 0);
        checkOutput("reset_valid", longint'(sample_valid), 0);
        rst_n = 1'b1;

        waitForValid(CLK_DIV + 64, cyc, ok);
        checkOutput("first_tick_found", longint'(ok), 1);
        checkOutput("first_tick_latency", cyc, CLK_DIV);
        checkOutput("first_saw_sample", longint'(sample), EXP_SAW0);
        @(negedge clk);
        checkOutput("valid_one_cycle", longint'(sample_valid), 0);

        applyStimulus(1, 0, 100);
        resetDut();
        waitForValid(CLK_DIV + 64, cyc, ok);
        checkOutput("square_tick_found", longint'(ok), 1);
        checkOutput("first_square_sample", longint'(sample), EXP_SQ0);
        flip_idx = -1;
        for (int s = 1; s <= 130 && flip_idx < 0; s++) begin
            waitForValid(CLK_DIV + 8, cyc, ok);
            if (!ok) begin
                checkOutput("square_tick_timeout", 0, 1);
                break;
            end
            if (sample < 0) flip_idx = s;
        end
        checkOutput("square_half_period", flip_idx, 101);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_sample", longint'(sample), 0);
        checkOutput("async_reset_valid", longint'(sample_valid), 0);
        repeat (2) @(negedge clk);

        applyStimulus(0, 5, 80);
        rst_n = 1'b1;
        waitForValid(CLK_DIV + 64, cyc, ok);
        checkOutput("sine_tick_found", longint'(ok), 1);
        checkOutput("first_sine_sample", longint'(sample), EXP_SINE0);

        for (int step = 0; step < 70; step++) begin
            repeat ($urandom_range(1, 600)) @(negedge clk);
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 127)));
        end
        repeat (CLK_DIV + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
